// File: rtl/dcache_wb_pkg.sv
// Shared types and geometry for the L1 D-cache writeback path.
// Values track the L1 cache parameter package (64 sets, 8 ways, 64-byte blocks).
package dcache_wb_pkg;
    localparam int PADDR_BITS     = 32;
    localparam int IDX_BITS       = 6;
    localparam int BLOCK_OFF_BITS = 6;
    localparam int TAG_BITS       = PADDR_BITS - 12;
    localparam int N_WAYS         = 8;
    localparam int WAY_BITS       = $clog2(N_WAYS);
    localparam int ROW_BITS       = 128;
    localparam int REFILL_CYCLES  = 4;
    localparam int BEAT_BITS      = 2;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(REFILL_CYCLES - 1);

    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic [IDX_BITS-1:0] idx;
        logic [WAY_BITS-1:0] way;
    } wb_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } wb_state_e;
endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry row FIFO between the data array read port and the release channel.
// The head is driven straight from registers, so data_resp never reaches rel_data combinationally.
module wb_skid_buffer
    import dcache_wb_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                push,
    input  logic [ROW_BITS-1:0] push_data,
    input  logic                pop,
    output logic [ROW_BITS-1:0] head_data,
    output logic [1:0]          occupancy
);
    logic       head_reg;
    logic       tail_reg;
    logic [1:0] count_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [ROW_BITS-1:0] data_reg;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    data_reg <= '0;
                else if (push && (tail_reg == 1'(gi)))
                    data_reg <= push_data;
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            head_reg  <= head_reg ^ pop;
            tail_reg  <= tail_reg ^ push;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = head_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign occupancy = count_reg;
endmodule

// File: rtl/dcache_writeback_unit.sv
// Evicts one D-cache block: reads it row by row from the data array and streams
// the rows as an in-order release burst through a two-entry skid buffer.
module dcache_writeback_unit
    import dcache_wb_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [TAG_BITS-1:0]           req_tag,
    input  logic [IDX_BITS-1:0]           req_idx,
    input  logic [WAY_BITS-1:0]           req_way,
    output logic                          data_req_valid,
    input  logic                          data_req_ready,
    output logic [IDX_BITS+BEAT_BITS-1:0] data_req_addr,
    output logic [N_WAYS-1:0]             data_req_way_en,
    input  logic [ROW_BITS-1:0]           data_resp,
    output logic                          rel_valid,
    input  logic                          rel_ready,
    output logic [PADDR_BITS-1:0]         rel_addr,
    output logic [BEAT_BITS-1:0]          rel_beat,
    output logic [ROW_BITS-1:0]           rel_data,
    output logic                          rel_last,
    output logic                          busy,
    output logic [IDX_BITS-1:0]           busy_idx,
    output logic                          wb_done
);
    wb_state_e             state_reg;
    wb_req_t               req_reg;
    logic [N_WAYS-1:0]     way_en_reg;
    logic [N_WAYS-1:0]     way_en_next;
    logic [BEAT_BITS-1:0]  rd_beat_reg;
    logic [BEAT_BITS-1:0]  tx_beat_reg;
    logic                  inflight_reg;
    logic                  wb_done_reg;
    logic [1:0]            occupancy;
    logic [2:0]            credit_used;
    logic                  req_fire;
    logic                  data_fire;
    logic                  rel_fire;

    generate
        for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_way_en
            assign way_en_next[gi] = (req_way == WAY_BITS'(gi));
        end
    endgenerate

    assign req_fire  = req_valid && req_ready;
    assign rel_fire  = rel_valid && rel_ready;
    assign data_fire = data_req_valid && data_req_ready;

    // A pop this cycle frees a slot in time for the response of a read issued now,
    // which is what lets the burst run at one beat per cycle with only two entries.
    assign credit_used    = 3'(occupancy) + 3'(inflight_reg) - 3'(rel_fire);
    assign data_req_valid = (state_reg == ST_READ) && (credit_used < 3'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            req_reg      <= '0;
            way_en_reg   <= '0;
            rd_beat_reg  <= '0;
            tx_beat_reg  <= '0;
            inflight_reg <= 1'b0;
            wb_done_reg  <= 1'b0;
        end else begin
            wb_done_reg  <= 1'b0;
            inflight_reg <= data_fire;
            if (rel_fire)
                tx_beat_reg <= tx_beat_reg + 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (req_fire) begin
                        req_reg     <= '{tag: req_tag, idx: req_idx, way: req_way};
                        way_en_reg  <= way_en_next;
                        rd_beat_reg <= '0;
                        tx_beat_reg <= '0;
                        state_reg   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (data_fire) begin
                        rd_beat_reg <= rd_beat_reg + 1'b1;
                        if (rd_beat_reg == LAST_BEAT)
                            state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rel_fire && (tx_beat_reg == LAST_BEAT)) begin
                        state_reg   <= ST_IDLE;
                        wb_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    wb_skid_buffer u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_reg),
        .push_data (data_resp),
        .pop       (rel_fire),
        .head_data (rel_data),
        .occupancy (occupancy)
    );

    assign req_ready       = (state_reg == ST_IDLE);
    assign busy            = (state_reg != ST_IDLE);
    assign busy_idx        = busy ? req_reg.idx : '0;
    assign wb_done         = wb_done_reg;
    assign data_req_addr   = {req_reg.idx, rd_beat_reg};
    assign data_req_way_en = way_en_reg;
    assign rel_valid       = (occupancy != 2'd0);
    assign rel_addr        = {req_reg.tag, req_reg.idx, {BLOCK_OFF_BITS{1'b0}}};
    assign rel_beat        = tx_beat_reg;
    assign rel_last        = (tx_beat_reg == LAST_BEAT);
endmodule
